// File: rtl/snake_head_stepper.sv
// snake_head_stepper
// Advances the snake head by one cell per accepted game tick. The X and Y
// coordinates are computed one after the other through a single shared
// external 5-bit adder, wrapped onto the playfield, and then published
// together with a one-cycle done pulse.
module snake_head_stepper #(
  parameter int GRID_W  = 32,
  parameter int GRID_H  = 24,
  parameter int START_X = 16,
  parameter int START_Y = 12
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       tick,
  input  logic [1:0] dir_in,
  input  logic       dir_valid,
  output logic [4:0] adder_a,
  output logic [4:0] adder_b,
  input  logic [4:0] adder_s,
  output logic [4:0] head_x,
  output logic [4:0] head_y,
  output logic [1:0] cur_dir,
  output logic       busy,
  output logic       done,
  output logic       tick_drop
);

  // Direction encodings.
  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_RIGHT = 2'b01;
  localparam logic [1:0] DIR_DOWN  = 2'b10;
  localparam logic [1:0] DIR_LEFT  = 2'b11;

  // Adder operands for the three possible deltas.
  localparam logic [4:0] DELTA_ZERO = 5'b00000;
  localparam logic [4:0] DELTA_INC  = 5'b00001;
  localparam logic [4:0] DELTA_DEC  = 5'b11111;

  // Playfield limits in adder-compatible widths. The 6-bit form lets a
  // 32-wide grid compare correctly: a 5-bit sum can never equal 32, so the
  // adder's own modulo-32 overflow already provides the wrap to 0.
  localparam logic [5:0] LIMIT_X = 6'(GRID_W);
  localparam logic [5:0] LIMIT_Y = 6'(GRID_H);
  localparam logic [4:0] MAX_X   = 5'(GRID_W - 1);
  localparam logic [4:0] MAX_Y   = 5'(GRID_H - 1);
  localparam logic [4:0] INIT_X  = 5'(START_X);
  localparam logic [4:0] INIT_Y  = 5'(START_Y);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ADD_X  = 2'd1,
    ADD_Y  = 2'd2,
    COMMIT = 2'd3
  } stateT;

  stateT      state;
  stateT      stateNext;
  logic [1:0] pendDir;
  logic [1:0] stepDir;
  logic       dirAccept;
  logic       stepStart;
  logic [4:0] nx;
  logic [4:0] ny;

  // X delta for a given direction: only left/right move horizontally.
  function automatic logic [4:0] deltaX(input logic [1:0] dir);
    case (dir)
      DIR_RIGHT: deltaX = DELTA_INC;
      DIR_LEFT:  deltaX = DELTA_DEC;
      default:   deltaX = DELTA_ZERO;
    endcase
  endfunction

  // Y delta for a given direction: up decrements, down increments.
  function automatic logic [4:0] deltaY(input logic [1:0] dir);
    case (dir)
      DIR_DOWN: deltaY = DELTA_INC;
      DIR_UP:   deltaY = DELTA_DEC;
      default:  deltaY = DELTA_ZERO;
    endcase
  endfunction

  // Fold the raw adder sum back onto the playfield. Stepping past the far
  // edge lands on 0; stepping below 0 shows up as 31 from the adder and is
  // replaced by the last legal cell.
  function automatic logic [4:0] wrapCoord(
    input logic [4:0] sum,
    input logic [4:0] delta,
    input logic [5:0] limit,
    input logic [4:0] maxCoord
  );
    if ((delta == DELTA_INC) && ({1'b0, sum} == limit)) begin
      wrapCoord = 5'd0;
    end else if ((delta == DELTA_DEC) && (sum == 5'd31)) begin
      wrapCoord = maxCoord;
    end else begin
      wrapCoord = sum;
    end
  endfunction

  // A direction request is dropped only when it would turn the snake back
  // onto itself; the check is against the direction actually in use.
  assign dirAccept = dir_valid && (dir_in != (cur_dir ^ 2'b10));
  // A same-cycle accepted request takes effect on the step it arrives with.
  assign stepDir   = dirAccept ? dir_in : pendDir;
  assign stepStart = (state == IDLE) && tick;

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Next-state decode and shared-adder operand steering.
  always_comb begin
    stateNext = state;
    adder_a   = 5'd0;
    adder_b   = 5'd0;
    case (state)
      IDLE: begin
        if (tick) begin
          stateNext = ADD_X;
        end
      end
      ADD_X: begin
        adder_a   = head_x;
        adder_b   = deltaX(cur_dir);
        stateNext = ADD_Y;
      end
      ADD_Y: begin
        adder_a   = head_y;
        adder_b   = deltaY(cur_dir);
        stateNext = COMMIT;
      end
      COMMIT: begin
        stateNext = IDLE;
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  // Direction bookkeeping: pending request and the direction of the step.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pendDir <= DIR_RIGHT;
      cur_dir <= DIR_RIGHT;
    end else begin
      if (dirAccept) begin
        pendDir <= dir_in;
      end
      if (stepStart) begin
        cur_dir <= stepDir;
      end
    end
  end

  // Wrapped intermediate coordinates captured from the shared adder.
  always_ff @(posedge clk) begin
    if (state == ADD_X) begin
      nx <= wrapCoord(adder_s, adder_b, LIMIT_X, MAX_X);
    end
    if (state == ADD_Y) begin
      ny <= wrapCoord(adder_s, adder_b, LIMIT_Y, MAX_Y);
    end
  end

  // Published head position, updated atomically when the step commits.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head_x <= INIT_X;
      head_y <= INIT_Y;
    end else if (state == COMMIT) begin
      head_x <= nx;
      head_y <= ny;
    end
  end

  // Registered status outputs: busy for the step, done aligned with COMMIT,
  // and a drop pulse for ticks that arrive while a step is running.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      tick_drop <= 1'b0;
    end else begin
      busy      <= (stateNext != IDLE);
      done      <= (state == ADD_Y);
      tick_drop <= tick && (state != IDLE);
    end
  end

endmodule

// File: tb/tb_snake_head_stepper.sv
// Bench for snake_head_stepper: a 32x24 instance driven through direction,
// wrap, drop and reset scenarios, plus a 20-wide instance for the
// non-power-of-two horizontal wrap.
module tb_snake_head_stepper;

  localparam int GW = 32;
  localparam int GH = 24;

  logic       clk;
  logic       resetn;
  logic       tick;
  logic [1:0] dir_in;
  logic       dir_valid;
  logic [4:0] adder_a, adder_b, adder_s;
  logic [4:0] head_x, head_y;
  logic [1:0] cur_dir;
  logic       busy, done, tick_drop;

  logic       tick20;
  logic [1:0] dir_in20;
  logic       dir_valid20;
  logic [4:0] adder_a20, adder_b20, adder_s20;
  logic [4:0] head_x20, head_y20;
  logic [1:0] cur_dir20;
  logic       busy20, done20, tick_drop20;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int         x;
    int         y;
    logic [1:0] dir;
  } expT;
  expT expQ[$];

  int         mdlX, mdlY;
  logic [1:0] mdlDir, mdlPend;

  assign adder_s   = adder_a + adder_b;
  assign adder_s20 = adder_a20 + adder_b20;

  snake_head_stepper #(.GRID_W(32), .GRID_H(24), .START_X(16), .START_Y(12)) dut (
    .clk(clk), .resetn(resetn), .tick(tick), .dir_in(dir_in), .dir_valid(dir_valid),
    .adder_a(adder_a), .adder_b(adder_b), .adder_s(adder_s),
    .head_x(head_x), .head_y(head_y), .cur_dir(cur_dir),
    .busy(busy), .done(done), .tick_drop(tick_drop)
  );

  snake_head_stepper #(.GRID_W(20), .GRID_H(24), .START_X(19), .START_Y(5)) dut20 (
    .clk(clk), .resetn(resetn), .tick(tick20), .dir_in(dir_in20), .dir_valid(dir_valid20),
    .adder_a(adder_a20), .adder_b(adder_b20), .adder_s(adder_s20),
    .head_x(head_x20), .head_y(head_y20), .cur_dir(cur_dir20),
    .busy(busy20), .done(done20), .tick_drop(tick_drop20)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: direction request filtering.
  task automatic modelDir(input bit dv, input logic [1:0] d);
    if (dv && (d != (mdlDir ^ 2'b10))) mdlPend = d;
  endtask

  // Model: one step using the pending direction, with playfield wrap.
  task automatic modelTick();
    mdlDir = mdlPend;
    case (mdlDir)
      2'b00: mdlY = (mdlY + GH - 1) % GH;
      2'b01: mdlX = (mdlX + 1) % GW;
      2'b10: mdlY = (mdlY + 1) % GH;
      default: mdlX = (mdlX + GW - 1) % GW;
    endcase
    expQ.push_back('{x: mdlX, y: mdlY, dir: mdlDir});
  endtask

  task automatic doReset();
    @(negedge clk);
    resetn = 1'b0;
    tick = 1'b0; dir_valid = 1'b0; dir_in = 2'b00;
    tick20 = 1'b0; dir_valid20 = 1'b0; dir_in20 = 2'b00;
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    mdlX = 16; mdlY = 12; mdlDir = 2'b01; mdlPend = 2'b01;
    expQ.delete();
  endtask

  // Drive one tick and check the committed head against the scoreboard.
  task automatic runStep(input bit dv, input logic [1:0] d, input string name);
    expT e;
    bit  got;
    modelDir(dv, d);
    modelTick();
    @(negedge clk);
    tick = 1'b1; dir_valid = dv; dir_in = d;
    @(negedge clk);
    tick = 1'b0; dir_valid = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      if (done) got = 1'b1;
      else @(negedge clk);
    end
    e = expQ.pop_front();
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL %s done_timeout got=0 want=1", name);
    end else begin
      @(negedge clk);
      if (head_x !== 5'(e.x) || head_y !== 5'(e.y) || cur_dir !== e.dir) begin
        failures++;
        $display("FAIL %s head got=(%0d,%0d) dir=%b want=(%0d,%0d) dir=%b",
                 name, head_x, head_y, cur_dir, e.x, e.y, e.dir);
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    resetn = 1'b0;
    #1;
    checks++; if (head_x !== 5'd16) begin failures++; $display("FAIL rst_head_x got=%0d want=16", head_x); end
    checks++; if (head_y !== 5'd12) begin failures++; $display("FAIL rst_head_y got=%0d want=12", head_y); end
    checks++; if (cur_dir !== 2'b01) begin failures++; $display("FAIL rst_cur_dir got=%b want=01", cur_dir); end
    checks++; if (busy !== 1'b0 || done !== 1'b0 || tick_drop !== 1'b0) begin
      failures++; $display("FAIL rst_status got=%b%b%b want=000", busy, done, tick_drop); end
    checks++; if (adder_a !== 5'd0 || adder_b !== 5'd0) begin
      failures++; $display("FAIL rst_adder got=%0d,%0d want=0,0", adder_a, adder_b); end
    doReset();
  endtask

  task automatic test_single_tick();
    expT e;
    doReset();
    modelTick();
    @(negedge clk);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    checks++; if (busy !== 1'b1 || adder_a !== 5'd16 || adder_b !== 5'd1) begin
      failures++; $display("FAIL addx_ops got busy=%b a=%0d b=%0d want 1,16,1", busy, adder_a, adder_b); end
    @(negedge clk);
    checks++; if (adder_a !== 5'd12 || adder_b !== 5'd0 || done !== 1'b0) begin
      failures++; $display("FAIL addy_ops got a=%0d b=%0d done=%b want 12,0,0", adder_a, adder_b, done); end
    @(negedge clk);
    checks++; if (done !== 1'b1 || busy !== 1'b1) begin
      failures++; $display("FAIL done_latency got done=%b busy=%b want 1,1", done, busy); end
    @(negedge clk);
    e = expQ.pop_front();
    checks++; if (head_x !== 5'(e.x) || head_y !== 5'(e.y) || cur_dir !== e.dir || done !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL single_head got=(%0d,%0d) dir=%b done=%b busy=%b want=(%0d,%0d) dir=%b done=0 busy=0",
                           head_x, head_y, cur_dir, done, busy, e.x, e.y, e.dir); end
  endtask

  task automatic test_reverse_ignored();
    doReset();
    @(negedge clk);
    dir_valid = 1'b1; dir_in = 2'b11;
    modelDir(1'b1, 2'b11);
    @(negedge clk);
    dir_valid = 1'b0;
    runStep(1'b0, 2'b00, "reverse_ignored");
  endtask

  task automatic test_same_cycle_dir();
    doReset();
    runStep(1'b1, 2'b00, "same_cycle_dir");
  endtask

  task automatic test_wrap32();
    doReset();
    for (int i = 0; i < 15; i++) runStep(1'b1, 2'b01, "walk_right");
    for (int i = 0; i < 12; i++) runStep(1'b1, 2'b00, "walk_up");
    checks++; if (head_x !== 5'd31 || head_y !== 5'd0) begin
      failures++; $display("FAIL corner got=(%0d,%0d) want=(31,0)", head_x, head_y); end
    runStep(1'b1, 2'b01, "wrap_right32");
    runStep(1'b1, 2'b00, "wrap_up");
    runStep(1'b1, 2'b11, "wrap_left");
    checks++; if (head_x !== 5'd31 || head_y !== 5'd23) begin
      failures++; $display("FAIL wrap_final got=(%0d,%0d) want=(31,23)", head_x, head_y); end
  endtask

  task automatic test_wrap20();
    bit got;
    doReset();
    @(negedge clk);
    tick20 = 1'b1; dir_valid20 = 1'b1; dir_in20 = 2'b01;
    @(negedge clk);
    tick20 = 1'b0; dir_valid20 = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      if (done20) got = 1'b1;
      else @(negedge clk);
    end
    checks++;
    if (!got) begin
      failures++; $display("FAIL wrap20 done_timeout got=0 want=1");
    end else begin
      @(negedge clk);
      if (head_x20 !== 5'd0 || head_y20 !== 5'd5) begin
        failures++; $display("FAIL wrap20 head got=(%0d,%0d) want=(0,5)", head_x20, head_y20);
      end
    end
  endtask

  task automatic test_back_to_back();
    int   drops = 0;
    int   dones = 0;
    expT  e;
    doReset();
    modelTick();
    @(negedge clk);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i == 1) tick = 1'b1;
      if (i == 2) tick = 1'b0;
      if (tick_drop) drops++;
      if (done) dones++;
      @(negedge clk);
    end
    e = expQ.pop_front();
    checks++; if (drops != 1) begin failures++; $display("FAIL tick_drop_count got=%0d want=1", drops); end
    checks++; if (dones != 1) begin failures++; $display("FAIL b2b_done_count got=%0d want=1", dones); end
    checks++; if (head_x !== 5'(e.x) || head_y !== 5'(e.y)) begin
      failures++; $display("FAIL b2b_head got=(%0d,%0d) want=(%0d,%0d)", head_x, head_y, e.x, e.y); end
  endtask

  task automatic test_reset_midstep();
    int dones = 0;
    doReset();
    runStep(1'b1, 2'b01, "pre_reset_step");
    @(negedge clk);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    @(negedge clk);
    #2;
    resetn = 1'b0;
    #1;
    checks++; if (head_x !== 5'd16 || head_y !== 5'd12 || busy !== 1'b0 || adder_a !== 5'd0) begin
      failures++; $display("FAIL midstep_reset got=(%0d,%0d) busy=%b a=%0d want=(16,12) busy=0 a=0",
                           head_x, head_y, busy, adder_a); end
    @(negedge clk);
    resetn = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (done) dones++;
      @(negedge clk);
    end
    checks++; if (dones != 0 || head_x !== 5'd16 || head_y !== 5'd12) begin
      failures++; $display("FAIL midstep_no_done got dones=%0d head=(%0d,%0d) want 0,(16,12)", dones, head_x, head_y); end
  endtask

  initial begin
    resetn = 1'b0;
    tick = 1'b0; dir_valid = 1'b0; dir_in = 2'b00;
    tick20 = 1'b0; dir_valid20 = 1'b0; dir_in20 = 2'b00;
    mdlX = 16; mdlY = 12; mdlDir = 2'b01; mdlPend = 2'b01;
    test_reset();
    test_single_tick();
    test_reverse_ignored();
    test_same_cycle_dir();
    test_wrap32();
    test_wrap20();
    test_back_to_back();
    test_reset_midstep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/snake_head_stepper.md
Name: snake_head_stepper

Overview:
- Sequences one shared external 5-bit ripple adder to advance the snake head by one cell per game tick.
- Computes the X coordinate and then the Y coordinate through the same adder, applies playfield wrap-around, and publishes the new head position with a done pulse.
- Sits between the game-tick generator and the body/collision logic.

Parameters:
GRID_W, 32, playfield width in cells (2..32); legal X is 0..GRID_W-1
GRID_H, 24, playfield height in cells (2..32); legal Y is 0..GRID_H-1
START_X, 16, head X after reset (must be < GRID_W)
START_Y, 12, head Y after reset (must be < GRID_H)

Ports:
clk  in  1  system clock, rising edge
resetn  in  1  asynchronous active-low reset
tick  in  1  step request, single-cycle pulse
dir_in  in  2  requested direction: 00 up (Y-1), 01 right (X+1), 10 down (Y+1), 11 left (X-1)
dir_valid  in  1  dir_in is sampled this cycle
adder_a  out  5  operand A to shared adder
adder_b  out  5  operand B to shared adder
adder_s  in  5  adder sum; combinational, same cycle, modulo 32, no carry
head_x  out  5  current head X
head_y  out  5  current head Y
cur_dir  out  2  direction applied on the last accepted step
busy  out  1  high while a step is in progress
done  out  1  one-cycle pulse when head_x/head_y update
tick_drop  out  1  one-cycle pulse when a tick arrives while busy

Behaviour:
- Clock and reset: one clock, clk. resetn is asynchronous and active-low.
- Reset values: head_x=START_X, head_y=START_Y, cur_dir=01, pend_dir=01, state=IDLE, busy=0, done=0, tick_drop=0. adder_a and adder_b are 0 in IDLE.
- Reset asserted mid-step abandons the step. No done pulse is issued.
- Direction register pend_dir:
  - On dir_valid, pend_dir loads dir_in unless dir_in is the exact reverse of cur_dir. The reverse pairs are 00/10 and 01/11. A reverse request is silently ignored.
  - dir_valid is honoured in every state.
  - If dir_valid and an accepted tick occur in the same cycle, the new dir_in is used for that step.
- Step deltas:
  - dX = +1 for 01, -1 (5'b11111) for 11, 0 otherwise.
  - dY = +1 for 10, -1 for 00, 0 otherwise.
- State machine, one adder operation per state:
  - IDLE: busy=0. When tick=1: latch step direction into cur_dir and go to ADD_X.
  - ADD_X: adder_a=head_x, adder_b=dX. Register the wrapped result into nx. Go to ADD_Y.
  - ADD_Y: adder_a=head_y, adder_b=dY. Register the wrapped result into ny. Go to COMMIT.
  - COMMIT: head_x<=nx, head_y<=ny, done=1 for this cycle. Go to IDLE.
- Latency: a tick accepted at cycle N gives done high at cycle N+3. The new head is visible at N+4. Throughput is one step per 4 cycles.
- busy is high in ADD_X, ADD_Y and COMMIT.
- Wrap rules, applied to adder_s:
  - Delta +1 and adder_s == GRID_W (or GRID_H): result 0. When the grid is 32, the adder's natural modulo-32 overflow to 0 is correct.
  - Delta -1 from coordinate 0: adder_s=31. Result is GRID_W-1 (or GRID_H-1).
  - Delta 0: result is adder_s unchanged.
- tick while busy (including in COMMIT): step is not queued; tick_drop=1 that cycle.
- Outputs are registered except adder_a/adder_b, which are decoded from state.

Test Plan:
- Reset, then one tick with no dir change -> done at cycle +3; head (17,12); cur_dir=01; adder_b=1 in ADD_X and 0 in ADD_Y.
- Reset, then dir_valid dir_in=11 -> ignored as a reverse; next tick gives head (17,12).
- Reset, dir_valid dir_in=00, tick in the same cycle -> head (16,11), cur_dir=00.
- Head at (31,0) with GRID_W=32: dir 01 tick -> (0,0). Then dir 00 tick -> (0,23). Then dir 11 tick -> (31,23).
- GRID_W=20, head_x=19, dir 01 tick -> head_x 0.
- Tick, then a second tick 2 cycles later -> tick_drop pulse, exactly one done, one-cell move. Separately, resetn pulsed low during ADD_Y -> head back to (16,12), no done pulse.
